muldiv_sequencer: RTL and testbench

//  Iterative RV32M multiply/divide unit that executes alongside the single-cycle ALU.

---
 rtl/muldiv_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Busy stalls the core while an op is in flight; Done pulses for one cycle when MDResult is valid.
module muldiv_sequencer #(
    parameter int XLEN          = 32,
    parameter bit EARLY_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Start,
    input  logic            Flush,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] MDResult
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_opnd;
    logic [2*XLEN-1:0] r_acc;
    logic              r_neg;
    logic              r_special;
    logic [XLEN-1:0]   r_special_val;
    logic [CW-1:0]     r_count;
    logic [XLEN-1:0]   r_result;

    logic              w_is_div;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_val;
    logic              w_neg;
    logic              w_last;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_shift_hi;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_dsel;
    logic [XLEN-1:0]   w_dfix;
    logic [XLEN-1:0]   w_fix_val;

    // Operand signedness by op: MULH/DIV/REM both, MULHSU rs1 only, the rest unsigned.
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (r_funct3)
            3'b001, 3'b100, 3'b110: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            3'b010:  w_a_signed = 1'b1;
            default: ;
        endcase
    end

    assign w_is_div = r_funct3[2];
    assign w_sa     = w_a_signed & r_a[XLEN-1];
    assign w_sb     = w_b_signed & r_b[XLEN-1];
    assign w_abs_a  = w_sa ? (~r_a + 1'b1) : r_a;
    assign w_abs_b  = w_sb ? (~r_b + 1'b1) : r_b;
    assign w_neg    = (w_is_div && r_funct3[1]) ? w_sa : (w_sa ^ w_sb);

    assign w_div0   = w_is_div && (r_b == '0);
    assign w_ovf    = w_is_div && !r_funct3[0] && (r_a == {1'b1, {(XLEN-1){1'b0}}})
                      && (r_b == '1);
    assign w_special = w_div0 || w_ovf;
    assign w_special_val = w_div0 ? (r_funct3[1] ? r_a : '1)
                                  : (r_funct3[1] ? '0 : r_a);

    assign w_last = (r_count == CW'(XLEN - 1));

    // Multiply: add multiplicand into the high half when the current multiplier bit is set.
    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

    // Divide: partial remainder stays below the divisor, so a borrow-free diff fits XLEN bits.
    assign w_shift_hi = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff     = w_shift_hi - {1'b0, r_opnd};
    assign w_ge       = ~w_diff[XLEN];
    assign w_div_next = {(w_ge ? w_diff[XLEN-1:0] : w_shift_hi[XLEN-1:0]),
                         r_acc[XLEN-2:0], w_ge};

    assign w_prod_fix = r_neg ? (~r_acc + 1'b1) : r_acc;
    assign w_dsel     = r_funct3[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    assign w_dfix     = r_neg ? (~w_dsel + 1'b1) : w_dsel;
    assign w_fix_val  = r_special ? r_special_val
                      : w_is_div  ? w_dfix
                      : (r_funct3[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0]
                      : w_prod_fix[2*XLEN-1:XLEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_state_next = S_PREP;
            S_PREP:  w_state_next = (EARLY_SPECIAL && w_special) ? S_DONE : S_CALC;
            S_CALC:  if (w_last) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (Flush) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_funct3      <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_opnd        <= '0;
            r_acc         <= '0;
            r_neg         <= 1'b0;
            r_special     <= 1'b0;
            r_special_val <= '0;
            r_count       <= '0;
            r_result      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start && !Flush) begin
                        r_funct3 <= Funct3;
                        r_a      <= SrcA;
                        r_b      <= SrcB;
                    end
                end
                S_PREP: begin
                    r_opnd        <= w_is_div ? w_abs_b : w_abs_a;
                    r_acc         <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                    r_neg         <= w_neg;
                    r_special     <= w_special;
                    r_special_val <= w_special_val;
                    r_count       <= '0;
                    if (EARLY_SPECIAL && w_special && !Flush) r_result <= w_special_val;
                end
                S_CALC: begin
                    r_acc   <= w_is_div ? w_div_next : w_mul_next;
                    r_count <= w_last ? '0 : r_count + 1'b1;
                end
                S_FIX: begin
                    if (!Flush) r_result <= w_fix_val;
                end
                default: ;
            endcase
        end
    end

    assign Busy     = (r_state != S_IDLE);
    assign Done     = (r_state == S_DONE);
    assign MDResult = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops, specials, flush/reset, protocol, random ops.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic        Flush;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic        Done;
    logic [31:0] MDResult;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = 32'h0;
    logic        prev_done = 1'b0;
    bit          done_stretched = 1'b0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(32), .EARLY_SPECIAL(1'b1)) dut (
        .clk(clk), .rst(rst), .Start(Start), .Flush(Flush), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done), .MDResult(MDResult)
    );

    always @(negedge clk) begin
        if (Done === 1'b1 && prev_done === 1'b1) done_stretched = 1'b1;
        prev_done = Done;
    end

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        p;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Funct3 = f;
        SrcA   = a;
        SrcB   = b;
        Start  = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int lat, output logic [31:0] res);
        lat = -1;
        res = 32'h0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (Done === 1'b1) begin
                lat = k;
                res = MDResult;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; Start = 1'b0; Flush = 1'b0; Funct3 = 3'd0; SrcA = 32'h0; SrcB = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", Busy); end
        checks++;
        if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", Done); end
        checks++;
        if (MDResult !== 32'h0) begin
            failures++; $display("FAIL reset_result got=%h want=00000000", MDResult);
        end
        rst = 1'b0;
        $display("reset: busy=%b done=%b result=%h", Busy, Done, MDResult);
    endtask

    task automatic test_mul_timing();
        logic [31:0] exp;
        logic [31:0] res = 32'h0;
        int          busy_bad = 0;
        int          done_k = -1;
        exp_q.push_back(32'h2A);
        issue(3'd0, 32'd7, 32'd6);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k <= 35 && Busy !== 1'b1) busy_bad++;
            if (Done === 1'b1) begin
                if (done_k < 0) done_k = k;
                res = MDResult;
            end
            if (k == 36) begin
                checks++;
                if (Busy !== 1'b0 || Done !== 1'b0) begin
                    failures++; $display("FAIL mul_idle_after got=%b%b want=00", Busy, Done);
                end
            end
        end
        checks++;
        if (busy_bad != 0) begin failures++; $display("FAIL mul_busy_window bad=%0d want=0", busy_bad); end
        checks++;
        if (done_k != 35) begin failures++; $display("FAIL mul_latency got=%0d want=35", done_k); end
        exp = exp_q.pop_front();
        last_exp = exp;
        checks++;
        if (res !== exp) begin failures++; $display("FAIL mul_7x6 got=%h want=%h", res, exp); end
        $display("MUL 7*6: result=%h latency=%0d", res, done_k);
    endtask

    task automatic test_directed();
        logic [2:0]  tf[12]   = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                  3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] ta[12]   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                                  32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] tb_[12]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'd2, 32'd2, 32'd7, 32'd7,
                                  32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] texp[12] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                  32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                                  32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
        int          tlat[12] = '{35, 35, 35, 35, 35, 35, 35, 35, 2, 2, 2, 2};
        int          lat;
        logic [31:0] res;
        logic [31:0] exp;
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(texp[i]);
            issue(tf[i], ta[i], tb_[i]);
            wait_done(40, lat, res);
            exp = exp_q.pop_front();
            last_exp = exp;
            checks++;
            if (res !== exp) begin
                failures++;
                $display("FAIL directed_%0d_result f3=%0d got=%h want=%h", i, tf[i], res, exp);
            end
            checks++;
            if (lat != tlat[i]) begin
                failures++;
                $display("FAIL directed_%0d_latency got=%0d want=%0d", i, lat, tlat[i]);
            end
            $display("directed f3=%0d a=%h b=%h result=%h latency=%0d", tf[i], ta[i], tb_[i], res, lat);
        end
    endtask

    task automatic test_flush();
        int          lat;
        logic [31:0] res;
        logic [31:0] exp;
        int          early_done = 0;
        issue(3'd0, 32'd123, 32'd456);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (Done === 1'b1) early_done++;
        end
        Flush = 1'b1;
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || early_done != 0) begin
            failures++;
            $display("FAIL flush_idle got busy=%b done=%b early=%0d want 0 0 0", Busy, Done, early_done);
        end
        checks++;
        if (MDResult !== last_exp) begin
            failures++; $display("FAIL flush_hold got=%h want=%h", MDResult, last_exp);
        end
        Flush = 1'b0; Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd5; Start = 1'b1;
        exp_q.push_back(32'd15);
        @(posedge clk);
        #1 Start = 1'b0;
        wait_done(40, lat, res);
        exp = exp_q.pop_front();
        last_exp = exp;
        checks++;
        if (res !== exp || lat != 35) begin
            failures++; $display("FAIL flush_restart got=%h lat=%0d want=%h lat=35", res, lat, exp);
        end
        $display("flush: restart result=%h latency=%0d", res, lat);
        @(negedge clk);
        Start = 1'b1; Flush = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0; Flush = 1'b0;
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("FAIL flush_beats_start got=%b want=0", Busy); end
        $display("flush+start in idle: busy=%b", Busy);
    endtask

    task automatic test_reset_midop();
        int seen = 0;
        issue(3'd5, 32'd1000, 32'd3);
        for (int k = 1; k <= 20; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || MDResult !== 32'h0) begin
            failures++;
            $display("FAIL reset_midop got busy=%b done=%b res=%h want 0 0 0", Busy, Done, MDResult);
        end
        rst = 1'b0;
        last_exp = 32'h0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (Done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL reset_no_done got=%0d want=0", seen); end
        $display("reset mid-op: busy=%b result=%h", Busy, MDResult);
    endtask

    task automatic test_start_held();
        int          ndone = 0;
        int          first_k = -1;
        int          second_k = -1;
        logic [31:0] exp;
        exp_q.push_back(32'd99);
        exp_q.push_back(32'd99);
        @(negedge clk);
        Funct3 = 3'd0; SrcA = 32'd9; SrcB = 32'd11; Start = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (Done === 1'b1) begin
                ndone++;
                if (first_k < 0) first_k = k; else if (second_k < 0) second_k = k;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                last_exp = exp;
                checks++;
                if (MDResult !== exp) begin
                    failures++; $display("FAIL held_result got=%h want=%h", MDResult, exp);
                end
            end
            if (k == 36) begin
                checks++;
                if (Busy !== 1'b0) begin failures++; $display("FAIL held_gap got=%b want=0", Busy); end
            end
            if (k == 37) begin
                checks++;
                if (Busy !== 1'b1) begin failures++; $display("FAIL held_reaccept got=%b want=1", Busy); end
            end
            if (k == 40) Start = 1'b0;
        end
        checks++;
        if (ndone != 2 || first_k != 35 || second_k != 71) begin
            failures++;
            $display("FAIL held_count got=%0d at %0d,%0d want=2 at 35,71", ndone, first_k, second_k);
        end
        $display("start held: dones=%0d at %0d,%0d", ndone, first_k, second_k);
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [31:0] res;
        int          lat;
        int          want_lat;
        int          sel;
        for (int i = 0; i < 1000; i++) begin
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 15);
            if (sel == 0) b = 32'h0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 20));
            else if (sel == 3) a = 32'($urandom_range(0, 100));
            want_lat = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
                       ? 2 : 35;
            exp_q.push_back(ref_model(f, a, b));
            issue(f, a, b);
            wait_done(40, lat, res);
            exp = exp_q.pop_front();
            last_exp = exp;
            checks++;
            if (res !== exp) begin
                failures++;
                $display("FAIL rand_%0d_result f3=%0d a=%h b=%h got=%h want=%h", i, f, a, b, res, exp);
            end
            checks++;
            if (lat != want_lat) begin
                failures++; $display("FAIL rand_%0d_latency got=%0d want=%0d", i, lat, want_lat);
            end
            $display("rand %0d f3=%0d a=%h b=%h result=%h latency=%0d", i, f, a, b, res, lat);
        end
    endtask

    task automatic test_final();
        checks++;
        if (done_stretched) begin failures++; $display("FAIL done_pulse got=stretched want=single"); end
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_empty got=%0d want=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_directed();
        test_flush();
        test_reset_midop();
        test_start_held();
        test_random();
        test_final();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
